// File: rtl/serterm_pkg.sv
// Shared serial-terminal definitions: ASCII flow-control bytes, the byte type
// and the XON/XOFF flow-state encoding.
package serterm_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t ASCII_XON  = 8'h11;
    localparam byte_t ASCII_XOFF = 8'h13;

    typedef enum logic [1:0] {
        FLOW_ON,
        SEND_XOFF,
        FLOW_OFF,
        SEND_XON
    } flow_state_e;

endpackage

// File: rtl/rx_flow_fifo_if.sv
// Handshake bundle of rx_flow_fifo: UART receive, controller, keyboard and UART
// transmit channels plus status. master = the buffer block, slave = its surroundings.
interface rx_flow_fifo_if #(
    parameter int DEPTH = 64
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          o_rx_ready;
    logic [7:0]    o_char;
    logic          o_valid;
    logic          i_ready;
    logic [7:0]    i_kb_data;
    logic          i_kb_valid;
    logic          o_kb_ready;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          i_break;
    logic [LW-1:0] o_level;
    logic          o_overrun;

    modport master (
        input  i_rx_data, i_rx_valid, i_ready, i_kb_data, i_kb_valid, i_tx_ready, i_break,
        output o_rx_ready, o_char, o_valid, o_kb_ready, o_tx_data, o_tx_valid, o_level, o_overrun
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_ready, i_kb_data, i_kb_valid, i_tx_ready, i_break,
        input  o_rx_ready, o_char, o_valid, o_kb_ready, o_tx_data, o_tx_valid, o_level, o_overrun
    );

endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO with first-word fall-through head and a registered occupancy count.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module sync_fifo
    import serterm_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  byte_t                  push_data,
    input  logic                   pop,
    output byte_t                  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array has no reset; the level counter alone defines which
    // entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;

endmodule

// File: rtl/rx_flow_fifo.sv
// Receive buffer with XON/XOFF flow control and a merged UART transmit register.
// Define RX_FLOW_FIFO_XONXOFF_EN to build the flow FSM; otherwise it is a pure FIFO.
module rx_flow_fifo
    import serterm_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int HIGH_WATER = 48,
    parameter int LOW_WATER  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    rx_flow_fifo_if.master bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rx_flow_fifo: DEPTH must be a power of two in 4..1024");
    end
    if (LOW_WATER >= HIGH_WATER || HIGH_WATER > DEPTH) begin : g_bad_water
        $error("rx_flow_fifo: need LOW_WATER < HIGH_WATER <= DEPTH");
    end

    logic          push, pop, full, empty;
    logic [LW-1:0] level;
    byte_t         head;
    logic          overrun_q, overrun_d;
    byte_t         tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_hs, load_ok, flow_pending;
    byte_t         flow_byte;

    assign pop       = !empty && bus.i_ready;
    assign push      = bus.i_rx_valid && (!full || pop);
    assign overrun_d = bus.i_rx_valid && !push;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (bus.i_rx_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign tx_hs   = tx_valid_q && bus.i_tx_ready;
    assign load_ok = (!tx_valid_q || bus.i_tx_ready) && !bus.i_break;

`ifdef RX_FLOW_FIFO_XONXOFF_EN
    flow_state_e state_q, state_d;
    logic        flow_loaded_q, flow_loaded_d;

    // flow_loaded marks that the register now holds this state's flow byte.
    always_comb begin
        state_d       = state_q;
        flow_loaded_d = flow_loaded_q;
        unique case (state_q)
            FLOW_ON:   if (level >= LW'(HIGH_WATER)) state_d = SEND_XOFF;
            SEND_XOFF: if (flow_loaded_q && tx_hs) begin
                           state_d       = FLOW_OFF;
                           flow_loaded_d = 1'b0;
                       end
            FLOW_OFF:  if (level <= LW'(LOW_WATER)) state_d = SEND_XON;
            SEND_XON:  if (flow_loaded_q && tx_hs) begin
                           state_d       = FLOW_ON;
                           flow_loaded_d = 1'b0;
                       end
            default:   state_d = FLOW_ON;
        endcase
        if (flow_pending && load_ok) flow_loaded_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= FLOW_ON;
            flow_loaded_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flow_loaded_q <= flow_loaded_d;
        end
    end

    assign flow_pending = (state_q == SEND_XOFF || state_q == SEND_XON) && !flow_loaded_q;
    assign flow_byte    = (state_q == SEND_XOFF) ? ASCII_XOFF : ASCII_XON;
`else
    assign flow_pending = 1'b0;
    assign flow_byte    = 8'h00;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        tx_valid_d = tx_valid_q && !tx_hs;
        tx_data_d  = tx_data_q;
        if (load_ok) begin
            if (flow_pending) begin
                tx_valid_d = 1'b1;
                tx_data_d  = flow_byte;
            end else if (bus.i_kb_valid) begin
                tx_valid_d = 1'b1;
                tx_data_d  = bus.i_kb_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_rx_ready = 1'b1;
    assign bus.o_char     = head;
    assign bus.o_valid    = !empty;
    assign bus.o_kb_ready = load_ok && !flow_pending;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_valid = tx_valid_q;
    assign bus.o_level    = level;
    assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_rx_flow_fifo.sv
// Directed bench for rx_flow_fifo: expected FIFO and transmit bytes are queued by the
// stimulus and compared by a negedge monitor on each handshake.
module tb_rx_flow_fifo;
    import serterm_pkg::*;

    localparam int DEPTH = 64;
    localparam int HIGH  = 48;
    localparam int LOW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_flow_fifo_if #(.DEPTH(DEPTH)) bus ();

    rx_flow_fifo #(.DEPTH(DEPTH), .HIGH_WATER(HIGH), .LOW_WATER(LOW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int    tests = 0;
    int    fails = 0;
    byte_t char_q[$];
    byte_t tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input byte_t base);
        for (int i = 0; i < n; i++) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = base + byte_t'(i);
            char_q.push_back(base + byte_t'(i));
            step();
        end
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic drain_to(input int lvl, input string name);
        int n = 0;
        bus.i_ready = 1'b1;
        while (int'(bus.o_level) > lvl && n < 300) begin
            step();
            n++;
        end
        bus.i_ready = 1'b0;
        check(name, 32'(bus.o_level), 32'(lvl));
    endtask

    // Scoreboard monitor: compares every completed handshake with the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_valid && bus.i_ready) begin
                if (char_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL char_unexpected: got 0x%0h expected none", bus.o_char);
                end else begin
                    check("char", 32'(bus.o_char), 32'(char_q.pop_front()));
                end
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (tx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got 0x%0h expected none", bus.o_tx_data);
                end else begin
                    check("tx", 32'(bus.o_tx_data), 32'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_ready    = 1'b0;
        bus.i_kb_data  = 8'h00;
        bus.i_kb_valid = 1'b0;
        bus.i_tx_ready = 1'b0;
        bus.i_break    = 1'b0;

        // Reset state
        step();
        step();
        check("rst_level", 32'(bus.o_level), 0);
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_overrun", 32'(bus.o_overrun), 0);
        check("rst_tx_valid", 32'(bus.o_tx_valid), 0);
        check("rst_tx_data", 32'(bus.o_tx_data), 0);
        check("rx_ready", 32'(bus.o_rx_ready), 1);
        rst = 1'b0;

        // Two bytes buffered, then consumed in order
        fill(2, 8'h41);
        check("basic_level", 32'(bus.o_level), 2);
        check("basic_head", 32'(bus.o_char), 32'h41);
        check("basic_valid", 32'(bus.o_valid), 1);
        drain_to(0, "basic_drain");
        check("basic_empty", 32'(bus.o_valid), 0);

        // Keyboard path
        bus.i_tx_ready = 1'b1;
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = 8'h0D;
        #1;
        check("kb_ready_idle", 32'(bus.o_kb_ready), 1);
        tx_q.push_back(8'h0D);
        step();
        bus.i_kb_valid = 1'b0;
        check("kb_tx_data", 32'(bus.o_tx_data), 32'h0D);
        check("kb_tx_valid", 32'(bus.o_tx_valid), 1);
        step();
        check("kb_tx_done", 32'(bus.o_tx_valid), 0);

        // Hold while transmitter stalls, then back-to-back reload
        bus.i_tx_ready = 1'b0;
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = 8'h61;
        tx_q.push_back(8'h61);
        step();
        bus.i_kb_data = 8'h62;
        #1;
        check("kb_blocked", 32'(bus.o_kb_ready), 0);
        step();
        check("tx_hold", 32'(bus.o_tx_data), 32'h61);
        bus.i_tx_ready = 1'b1;
        #1;
        check("kb_ready_hs", 32'(bus.o_kb_ready), 1);
        tx_q.push_back(8'h62);
        step();
        bus.i_kb_valid = 1'b0;
        check("back_to_back", 32'(bus.o_tx_data), 32'h62);
        step();
        check("b2b_done", 32'(bus.o_tx_valid), 0);

        // Break blocks loads
        bus.i_break    = 1'b1;
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = 8'h63;
        #1;
        check("break_kb_ready", 32'(bus.o_kb_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("break_tx_valid", 32'(bus.o_tx_valid), 0);
        end
        bus.i_break = 1'b0;
        #1;
        check("unbreak_kb_ready", 32'(bus.o_kb_ready), 1);
        tx_q.push_back(8'h63);
        step();
        bus.i_kb_valid = 1'b0;
        check("unbreak_tx", 32'(bus.o_tx_data), 32'h63);
        step();

        // Break does not withdraw a loaded byte
        bus.i_tx_ready = 1'b0;
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = 8'h64;
        tx_q.push_back(8'h64);
        step();
        bus.i_kb_valid = 1'b0;
        bus.i_break    = 1'b1;
        step();
        check("break_keep_valid", 32'(bus.o_tx_valid), 1);
        check("break_keep_data", 32'(bus.o_tx_data), 32'h64);
        bus.i_tx_ready = 1'b1;
        step();
        check("break_hs_done", 32'(bus.o_tx_valid), 0);
        bus.i_break = 1'b0;

`ifdef RX_FLOW_FIFO_XONXOFF_EN
        // XOFF two cycles after the high watermark, then XON at the low watermark
        tx_q.push_back(ASCII_XOFF);
        fill(HIGH, 8'h80);
        check("hw_level", 32'(bus.o_level), 32'(HIGH));
        check("xoff_n", 32'(bus.o_tx_valid), 0);
        step();
        check("xoff_n1", 32'(bus.o_tx_valid), 0);
        step();
        check("xoff_valid", 32'(bus.o_tx_valid), 1);
        check("xoff_data", 32'(bus.o_tx_data), 32'(ASCII_XOFF));
        for (int i = 0; i < 4; i++) begin
            step();
            check("xoff_once", 32'(bus.o_tx_valid), 0);
        end
        tx_q.push_back(ASCII_XON);
        drain_to(LOW, "lw_level");
        step();
        check("xon_n1", 32'(bus.o_tx_valid), 0);
        step();
        check("xon_valid", 32'(bus.o_tx_valid), 1);
        check("xon_data", 32'(bus.o_tx_data), 32'(ASCII_XON));
        for (int i = 0; i < 3; i++) begin
            step();
            check("xon_once", 32'(bus.o_tx_valid), 0);
        end
        drain_to(0, "flow_drain");

        // Keyboard byte arriving as XOFF becomes pending waits behind it
        fill(HIGH, 8'hC0);
        step();
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = 8'h61;
        #1;
        check("kb_vs_xoff_ready", 32'(bus.o_kb_ready), 0);
        tx_q.push_back(ASCII_XOFF);
        tx_q.push_back(8'h61);
        step();
        check("kb_vs_xoff_first", 32'(bus.o_tx_data), 32'(ASCII_XOFF));
        check("kb_vs_xoff_kbrdy", 32'(bus.o_kb_ready), 1);
        step();
        bus.i_kb_valid = 1'b0;
        check("kb_vs_xoff_second", 32'(bus.o_tx_data), 32'h61);
        step();
        tx_q.push_back(ASCII_XON);
        drain_to(0, "kb_xoff_drain");
        tx_q.push_back(ASCII_XOFF);
`endif

        // Full FIFO: overrun drop, then push with simultaneous pop
        fill(DEPTH, 8'h00);
        check("full_level", 32'(bus.o_level), 32'(DEPTH));
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'h55;
        step();
        bus.i_rx_valid = 1'b0;
        check("overrun_pulse", 32'(bus.o_overrun), 1);
        check("overrun_level", 32'(bus.o_level), 32'(DEPTH));
        step();
        check("overrun_one_cycle", 32'(bus.o_overrun), 0);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'hAA;
        bus.i_ready    = 1'b1;
        char_q.push_back(8'hAA);
        step();
        bus.i_rx_valid = 1'b0;
        bus.i_ready    = 1'b0;
        check("full_pushpop_level", 32'(bus.o_level), 32'(DEPTH));
        check("full_pushpop_ovr", 32'(bus.o_overrun), 0);
`ifdef RX_FLOW_FIFO_XONXOFF_EN
        tx_q.push_back(ASCII_XON);
`endif
        drain_to(0, "full_drain");

`ifndef RX_FLOW_FIFO_XONXOFF_EN
        // Pure FIFO: no flow bytes however full it gets
        fill(60, 8'h20);
        for (int i = 0; i < 8; i++) step();
        check("no_flow_tx", 32'(bus.o_tx_valid), 0);
        check("no_flow_level", 32'(bus.o_level), 60);
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = 8'h0D;
        tx_q.push_back(8'h0D);
        step();
        bus.i_kb_valid = 1'b0;
        check("no_flow_kb", 32'(bus.o_tx_data), 32'h0D);
        step();
        drain_to(0, "no_flow_drain");
`endif
        for (int i = 0; i < 4; i++) step();

        // Reset mid-operation discards buffered and loaded bytes
        bus.i_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = 8'hE0 + byte_t'(i);
            step();
        end
        bus.i_rx_valid = 1'b0;
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = 8'h7E;
        step();
        bus.i_kb_valid = 1'b0;
        check("pre_rst_level", 32'(bus.o_level), 3);
        check("pre_rst_tx", 32'(bus.o_tx_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_level", 32'(bus.o_level), 0);
        check("mid_rst_valid", 32'(bus.o_valid), 0);
        check("mid_rst_tx_valid", 32'(bus.o_tx_valid), 0);
        check("mid_rst_tx_data", 32'(bus.o_tx_data), 0);
        bus.i_tx_ready = 1'b1;
        bus.i_ready    = 1'b1;
        for (int i = 0; i < 3; i++) step();

        check("char_queue_empty", 32'(char_q.size()), 0);
        check("tx_queue_empty", 32'(tx_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_flow_fifo.md
# rx_flow_fifo

Receive buffer and software flow-control stage between the PC UART and the terminal's character/VRAM controller. It absorbs bursts from the host while the controller is stalled (scrolling, clearing), and sends XOFF/XON to the host when occupancy crosses watermarks. It also owns the UART transmit channel, merging flow-control bytes with keyboard bytes.

## Interface
- DEPTH, 64: FIFO entries; power of two, 4..1024.
- HIGH_WATER, 48: occupancy at or above which XOFF is sent.
- LOW_WATER, 16: occupancy at or below which XON is sent; must be < HIGH_WATER.
- i_clk  in  1  system clock (12 MHz).
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_rx_data  in  8  byte from UART receiver.
- i_rx_valid  in  1  receiver byte valid.
- o_rx_ready  out  1  constant 1; the receiver is never stalled.
- o_char  out  8  FIFO head byte to controller.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  controller consumes head.
- i_kb_data  in  8  keyboard byte.
- i_kb_valid  in  1  keyboard byte valid.
- o_kb_ready  out  1  keyboard byte accepted.
- o_tx_data  out  8  byte to UART transmitter.
- o_tx_valid  out  1  transmit byte valid.
- i_tx_ready  in  1  transmitter accepts.
- i_break  in  1  break in progress; blocks new transmit loads.
- o_level  out  $clog2(DEPTH)+1  registered occupancy.
- o_overrun  out  1  one-cycle pulse when a received byte is dropped.

## Operation
- Push: i_rx_valid while not full, or while full with a pop in the same cycle. Otherwise the byte is dropped and o_overrun pulses.
- Pop: o_valid && i_ready. o_char is the head entry, read combinationally from the array, first-word fall-through.
- Pointers are log2(DEPTH) bits and wrap naturally. Level is tracked in a separate counter: +1 on push only, -1 on pop only, unchanged on both.
- Flow FSM states and transitions:
  - FLOW_ON -> SEND_XOFF when o_level >= HIGH_WATER.
  - SEND_XOFF -> FLOW_OFF when the XOFF byte (0x13) completes its transmit handshake.
  - FLOW_OFF -> SEND_XON when o_level <= LOW_WATER.
  - SEND_XON -> FLOW_ON when the XON byte (0x11) completes its handshake.
- Transmit output register (o_tx_data, o_tx_valid):
  - Loads when empty, or in the cycle its current byte handshakes, and only if i_break is low.
  - Priority: a pending flow byte (state SEND_XOFF/SEND_XON with that byte not yet loaded) beats keyboard.
  - o_kb_ready = load permitted && no pending flow byte.
- AXI rule: once o_tx_valid is high, o_tx_data is stable until the handshake. i_break does not withdraw a loaded byte.
- Flow-control bytes from the host are passed to the FIFO unchanged (no filtering).

## Timing
- Reset values: FIFO empty, pointers 0, o_level 0, o_valid 0, o_overrun 0, o_tx_valid 0, o_tx_data 0x00, state FLOW_ON.
- Receive latency: byte pushed in cycle N gives o_valid=1 in cycle N+1; o_level updates in N+1.
- XOFF latency: o_level reaches HIGH_WATER in cycle N -> state SEND_XOFF in N+1 -> o_tx_valid=1 with 0x13 in N+2, provided the transmit register is free and i_break is low.
- Back-to-back transmit: a new byte may load in the same cycle the previous one handshakes. Full throughput is one byte per cycle.
- Reset mid-operation: all buffered bytes are discarded and any loaded transmit byte is dropped.

## Configuration
- RX_FLOW_FIFO_XONXOFF_EN defined: flow FSM and flow-byte injection are present, as described above.
- Macro undefined: the FSM is absent and the block is a pure FIFO. o_tx_* is the keyboard path through the output register; HIGH_WATER and LOW_WATER are ignored.

## Structure
- Shared package serterm_pkg holds:
  - ASCII_XON = 8'h11, ASCII_XOFF = 8'h13.
  - The flow state enum: FLOW_ON, SEND_XOFF, FLOW_OFF, SEND_XON.
- One sub-module, sync_fifo (parameter DEPTH; push/pop/full/empty/level), which holds the array and pointers.
- The flow FSM and transmit mux live in rx_flow_fifo.

## Test plan
- Reset, then push 0x41, 0x42 with i_ready=0 -> o_level=2, o_char=0x41. Raise i_ready -> 0x41 then 0x42 consumed, o_valid=0.
- Push 48 bytes with i_ready=0 -> exactly one 0x13 on o_tx_* two cycles after o_level=48. Drain to 16 -> exactly one 0x11 follows.
- Fill to 64, push 0x55 -> o_overrun pulses one cycle, o_level stays 64. Push with a simultaneous pop at full -> accepted, o_level stays 64.
- Keyboard 0x61 valid on the same cycle XOFF becomes pending, i_tx_ready=1 -> 0x13 transmitted first, then 0x61; no byte lost.
- i_break=1 with keyboard valid -> o_kb_ready=0, o_tx_valid stays 0. Release i_break -> byte transmitted.
- Macro undefined, push 60 bytes -> no flow bytes on o_tx_*; keyboard 0x0D passes unchanged.
